// File: rtl/vga_text_render.sv
// vga_text_render: 70x30 character text console renderer for a 640x480 VGA
// timing controller. Holds a scrolling text buffer fed by a write port and
// renders 9x16 character cells through an external font ROM, with a blinking
// reverse-video cursor.
//
// Ports:
//   pclk, reset        pixel clock, synchronous active-high reset
//   h_addr, v_addr     current pixel column/row from the timing controller
//   valid              active-video flag
//   vga_data           registered {R,G,B} pixel, 3 pclk after h/v/valid sampled
//   wr_valid, wr_char  character write request / ASCII code
//   wr_ready           high only while idle; write accepted on valid & ready
//   font_addr          {char, glyph_row} to the external font ROM
//   font_data          glyph row one cycle after font_addr, bit 7 leftmost
module vga_text_render #(
  parameter logic [23:0] FG_COLOR     = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR     = 24'h000000,
  parameter int unsigned BLINK_CYCLES = 12500000
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [9:0]  h_addr,
  input  logic [9:0]  v_addr,
  input  logic        valid,
  output logic [23:0] vga_data,
  input  logic        wr_valid,
  input  logic [7:0]  wr_char,
  output logic        wr_ready,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data
);

  localparam int unsigned COLS   = 70;
  localparam int unsigned ROWS   = 30;
  localparam int unsigned CELLS  = COLS * ROWS;
  localparam int unsigned AW     = 12;
  localparam int unsigned CELL_W = 9;
  localparam int unsigned CELL_H = 16;
  localparam int unsigned BW     = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [7:0]  SPACE  = 8'h20;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_CLEAR} state_t;

  // Per-pixel attributes carried alongside the text/font lookups.
  typedef struct packed {
    logic       valid;
    logic [3:0] px;
    logic       in_h;
    logic       cur;
  } pix_t;

  // (base + off) mod ROWS for operands already below ROWS.
  function automatic logic [4:0] phys_row(input logic [4:0] base, input logic [4:0] off);
    logic [5:0] sum;
    sum = 6'(base) + 6'(off);
    return (sum >= 6'(ROWS)) ? 5'(sum - 6'(ROWS)) : 5'(sum);
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [4:0] prow, input logic [6:0] col);
    return AW'(prow) * AW'(COLS) + AW'(col);
  endfunction

  state_t        state, next_state;
  logic [AW-1:0] fill_cnt, next_fill;
  logic [6:0]    cur_col, next_col;
  logic [4:0]    cur_row, next_row;
  logic [4:0]    top, next_top;
  logic [4:0]    cur_prow_c;
  logic          newline_c;
  logic          mem_we_c;
  logic [AW-1:0] mem_waddr_c;
  logic [7:0]    mem_wdata_c;

  assign cur_prow_c = phys_row(top, cur_row);

  // Control state register; wr_ready mirrors the idle state one-for-one.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state    <= ST_INIT;
      fill_cnt <= '0;
      cur_col  <= '0;
      cur_row  <= '0;
      top      <= '0;
      wr_ready <= 1'b0;
    end else begin
      state    <= next_state;
      fill_cnt <= next_fill;
      cur_col  <= next_col;
      cur_row  <= next_row;
      top      <= next_top;
      wr_ready <= (next_state == ST_IDLE);
    end
  end

  // Next-state, cursor update and buffer write port.
  always_comb begin
    next_state  = state;
    next_fill   = fill_cnt;
    next_col    = cur_col;
    next_row    = cur_row;
    next_top    = top;
    newline_c   = 1'b0;
    mem_we_c    = 1'b0;
    mem_waddr_c = '0;
    mem_wdata_c = SPACE;

    case (state)
      ST_INIT: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = fill_cnt;
        if (fill_cnt == AW'(CELLS - 1)) begin
          next_state = ST_IDLE;
          next_fill  = '0;
        end else begin
          next_fill = fill_cnt + AW'(1);
        end
      end

      ST_IDLE: begin
        if (wr_valid) begin
          if (wr_char >= 8'h20 && wr_char <= 8'h7E) begin
            mem_we_c    = 1'b1;
            mem_waddr_c = cell_addr(cur_prow_c, cur_col);
            mem_wdata_c = wr_char;
            if (cur_col == 7'(COLS - 1)) begin
              next_col  = '0;
              newline_c = 1'b1;
            end else begin
              next_col = cur_col + 7'(1);
            end
          end else if (wr_char == 8'h0A) begin
            next_col  = '0;
            newline_c = 1'b1;
          end else if (wr_char == 8'h08 && cur_col != '0) begin
            // Backspace erases the cell it moves onto; no wrap to previous row.
            next_col    = cur_col - 7'(1);
            mem_we_c    = 1'b1;
            mem_waddr_c = cell_addr(cur_prow_c, cur_col - 7'(1));
          end
        end
      end

      ST_CLEAR: begin
        // top has already advanced, so cursor row 29 is the fresh bottom line.
        mem_we_c    = 1'b1;
        mem_waddr_c = cell_addr(cur_prow_c, 7'(fill_cnt));
        if (fill_cnt == AW'(COLS - 1)) begin
          next_state = ST_IDLE;
          next_fill  = '0;
        end else begin
          next_fill = fill_cnt + AW'(1);
        end
      end

      default: next_state = ST_INIT;
    endcase

    // Newline: move down, or scroll by rotating the physical row origin.
    if (newline_c) begin
      if (cur_row != 5'(ROWS - 1)) begin
        next_row = cur_row + 5'(1);
      end else begin
        next_top   = (top == 5'(ROWS - 1)) ? '0 : top + 5'(1);
        next_state = ST_CLEAR;
        next_fill  = '0;
      end
    end
  end

  // Render address decode for the pixel currently presented.
  logic [6:0]    r_col_c;
  logic [3:0]    r_px_c;
  logic [5:0]    r_row_c;
  logic          r_in_h_c;
  logic          r_in_v_c;
  logic          r_cur_c;
  logic [AW-1:0] rd_addr_c;

  assign r_col_c   = 7'(h_addr / 10'(CELL_W));
  assign r_px_c    = 4'(h_addr % 10'(CELL_W));
  assign r_row_c   = v_addr[9:4];
  assign r_in_h_c  = h_addr < 10'(COLS * CELL_W);
  assign r_in_v_c  = v_addr < 10'(ROWS * CELL_H);
  assign r_cur_c   = r_in_h_c && r_in_v_c && (r_col_c == cur_col) && (r_row_c == 6'(cur_row));
  assign rd_addr_c = (r_in_h_c && r_in_v_c) ? cell_addr(phys_row(top, r_row_c[4:0]), r_col_c) : '0;

  // Text buffer: independent write and read ports; a same-cell read sees old data.
  logic [7:0] text_mem [CELLS];
  logic [7:0] rd_data;

  always_ff @(posedge pclk) begin
    if (mem_we_c && !reset) begin
      text_mem[mem_waddr_c] <= mem_wdata_c;
    end
    rd_data <= text_mem[rd_addr_c];
  end

  // Blink phase generator.
  logic [BW-1:0] blink_cnt;
  logic          blink;

  always_ff @(posedge pclk) begin
    if (reset) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // Three-stage render pipeline: text read, font address, font data -> pixel.
  pix_t       s1, s2, s3;
  logic [3:0] s1_gy;
  logic [2:0] bit_idx_c;
  logic       glyph_on_c;
  logic       fg_sel_c;

  assign bit_idx_c  = 3'(4'd7 - s3.px);
  assign glyph_on_c = s3.in_h && (s3.px < 4'd8) && font_data[bit_idx_c];
  assign fg_sel_c   = glyph_on_c ^ (s3.cur && blink);

  always_ff @(posedge pclk) begin
    if (reset) begin
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      s1_gy     <= '0;
      font_addr <= '0;
      vga_data  <= '0;
    end else begin
      s1        <= '{valid: valid, px: r_px_c, in_h: r_in_h_c, cur: r_cur_c};
      s1_gy     <= v_addr[3:0];
      s2        <= s1;
      font_addr <= s1.valid ? {rd_data, s1_gy} : '0;
      s3        <= s2;
      if (!s3.valid) begin
        vga_data <= '0;
      end else begin
        vga_data <= fg_sel_c ? FG_COLOR : BG_COLOR;
      end
    end
  end

endmodule

// File: tb/tb_vga_text_render.sv
// Directed bench for vga_text_render: buffer contents are observed through the
// character code on font_addr, pixels through vga_data with a small font model.
module tb_vga_text_render;

  localparam logic [23:0] FG = 24'hF0E0D0;
  localparam logic [23:0] BG = 24'h102030;

  logic        pclk = 1'b0;
  logic        reset;
  logic [9:0]  h_addr;
  logic [9:0]  v_addr;
  logic        valid;
  logic [23:0] vga_data;
  logic        wr_valid;
  logic [7:0]  wr_char;
  logic        wr_ready;
  logic [11:0] font_addr;
  logic [7:0]  font_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rst_cyc;
  int n;
  int bad;
  logic [23:0] pv;
  logic [23:0] exp_px;

  vga_text_render #(
    .FG_COLOR    (FG),
    .BG_COLOR    (BG),
    .BLINK_CYCLES(4)
  ) dut (
    .pclk     (pclk),
    .reset    (reset),
    .h_addr   (h_addr),
    .v_addr   (v_addr),
    .valid    (valid),
    .vga_data (vga_data),
    .wr_valid (wr_valid),
    .wr_char  (wr_char),
    .wr_ready (wr_ready),
    .font_addr(font_addr),
    .font_data(font_data)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  // Font ROM model: 'A' lights the leftmost pixel, 'B' the rightmost.
  function automatic logic [7:0] glyph(input logic [11:0] a);
    case (a[11:4])
      8'h41:   return 8'h80;
      8'h42:   return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge pclk) font_data <= glyph(font_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!wr_ready && k < 3000) begin
      @(posedge pclk); #1;
      k++;
    end
    if (!wr_ready) check("ready_timeout", 32'(wr_ready), 32'd1);
  endtask

  task automatic send(input logic [7:0] c);
    wait_ready();
    wr_char  = c;
    wr_valid = 1'b1;
    @(posedge pclk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (!wr_ready && cnt < 5000) begin
      cnt++;
      @(posedge pclk); #1;
    end
  endtask

  task automatic check_cell(input string tag, input int col, input int row, input logic [7:0] c);
    logic [11:0] want;
    h_addr = 10'(col * 9);
    v_addr = 10'(row * 16);
    valid  = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    want = {c, 4'h0};
    check(tag, 32'(font_addr), 32'(want));
  endtask

  task automatic pixel(input int h, input int v, output logic [23:0] px);
    h_addr = 10'(h);
    v_addr = 10'(v);
    valid  = 1'b1;
    repeat (4) @(posedge pclk);
    #1;
    px = vga_data;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_char = 8'h00;
    h_addr = '0; v_addr = '0; valid = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    check("reset_wr_ready", 32'(wr_ready), 32'd0);
    check("reset_vga", 32'(vga_data), 32'd0);
    check("reset_font_addr", 32'(font_addr), 32'd0);
    rst_cyc = cyc;
    reset = 1'b0;

    // Power-up fill: busy for exactly the cell count, black output while blanked.
    n = 0; bad = 0;
    while (!wr_ready && n < 5000) begin
      if (vga_data !== 24'h0) bad++;
      n++;
      @(posedge pclk); #1;
    end
    check("init_busy_cycles", 32'(n), 32'd2100);
    check("init_vga_zero", 32'(bad), 32'd0);
    check_cell("init_cell_0_0", 0, 0, 8'h20);
    check_cell("init_cell_69_29", 69, 29, 8'h20);

    // Cursor at (0,0) over a blank glyph: blink phase is known from the reset edge.
    h_addr = 10'd0; v_addr = 10'd0; valid = 1'b1;
    repeat (4) @(posedge pclk);
    #1;
    for (int i = 0; i < 12; i++) begin
      exp_px = ((((cyc - 1 - rst_cyc) / 4) % 2) == 1) ? FG : BG;
      check("blink_cursor", 32'(vga_data), 32'(exp_px));
      @(posedge pclk); #1;
    end
    valid = 1'b0;
    repeat (4) @(posedge pclk);
    #1;
    check("blank_vga_zero", 32'(vga_data), 32'd0);

    // First glyph, pixel colours and font address.
    send(8'h41);
    pixel(0, 0, pv);
    check("glyph_px0_fg", 32'(pv), 32'(FG));
    check("font_addr_41", 32'(font_addr), 32'h410);
    pixel(1, 0, pv);
    check("glyph_px1_bg", 32'(pv), 32'(BG));
    h_addr = 10'd0;
    repeat (3) @(posedge pclk);
    #1;
    check("latency_before", 32'(vga_data), 32'(BG));
    @(posedge pclk); #1;
    check("latency_at3", 32'(vga_data), 32'(FG));
    pixel(630, 0, pv);
    check("h630_bg", 32'(pv), 32'(BG));

    // Backspace and ignored control codes.
    send(8'h08);
    check_cell("bs_erase_col0", 0, 0, 8'h20);
    send(8'h08);
    send(8'h41); send(8'h42); send(8'h43); send(8'h44); send(8'h45);
    send(8'h08);
    check_cell("bs_col5_erase", 4, 0, 8'h20);
    check_cell("bs_col5_keep3", 3, 0, 8'h44);
    send(8'h5A);
    send(8'h07);
    send(8'h31);
    check_cell("bs_col0_noop", 0, 0, 8'h41);
    check_cell("bs_cursor_col4", 4, 0, 8'h5A);
    check_cell("other_ignored", 5, 0, 8'h31);
    check_cell("cell_6_0_blank", 6, 0, 8'h20);

    // Cell 1 holds 'B': rightmost glyph pixel lit, spacer column background.
    pixel(16, 0, pv);
    check("px7_fg", 32'(pv), 32'(FG));
    pixel(17, 0, pv);
    check("px8_bg", 32'(pv), 32'(BG));
    pixel(9, 0, pv);
    check("b_px0_bg", 32'(pv), 32'(BG));

    // Line wrap after column 69.
    send(8'h0A);
    for (int i = 0; i < 70; i++) send(8'h41 + 8'(i % 26));
    send(8'h7E);
    send(8'h7F);
    send(8'h21);
    check_cell("wrap_row1_col0", 0, 1, 8'h41);
    check_cell("wrap_row1_col69", 69, 1, 8'h52);
    check_cell("wrap_71st_char", 0, 2, 8'h7E);
    check_cell("del_ignored", 1, 2, 8'h21);
    check_cell("row0_col69_blank", 69, 0, 8'h20);

    // Scroll at the bottom line.
    repeat (27) send(8'h0A);
    send(8'h58);
    send(8'h59);
    send(8'h0A);
    count_busy(n);
    check("scroll_busy_cycles", 32'(n), 32'd70);
    check_cell("scroll_old29_to28_a", 0, 28, 8'h58);
    check_cell("scroll_old29_to28_b", 1, 28, 8'h59);
    check_cell("scroll_new29_c0", 0, 29, 8'h20);
    check_cell("scroll_new29_c4", 4, 29, 8'h20);
    check_cell("scroll_new29_c69", 69, 29, 8'h20);
    check_cell("scroll_row0_c0", 0, 0, 8'h41);
    check_cell("scroll_row0_c69", 69, 0, 8'h52);
    check_cell("scroll_row1_c0", 0, 1, 8'h7E);
    send(8'h43);
    check_cell("after_scroll_write", 0, 29, 8'h43);

    // Reset in the middle of a clear restarts the full fill.
    send(8'h0A);
    repeat (10) @(posedge pclk);
    #1;
    h_addr = 10'd0; v_addr = 10'd0; valid = 1'b1;
    reset = 1'b1;
    @(posedge pclk); #1;
    check("midclr_reset_ready", 32'(wr_ready), 32'd0);
    check("midclr_reset_vga", 32'(vga_data), 32'd0);
    check("midclr_reset_font", 32'(font_addr), 32'd0);
    reset = 1'b0;
    @(posedge pclk); #1;
    check("post_reset_vga", 32'(vga_data), 32'd0);
    check("post_reset_font", 32'(font_addr), 32'd0);
    count_busy(n);
    check("reinit_busy_cycles", 32'(n), 32'd2099);
    check_cell("reinit_cell_0_0", 0, 0, 8'h20);
    check_cell("reinit_cell_0_1", 0, 1, 8'h20);
    send(8'h42);
    check_cell("reinit_cursor_home", 0, 0, 8'h42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_text_render.md
VGA_TEXT_RENDER -- requirements
Module: vga_text_render

Interface
REQ-001 SHALL have parameter FG_COLOR, 24'hFFFFFF, glyph foreground RGB.
REQ-002 SHALL have parameter BG_COLOR, 24'h000000, background RGB.
REQ-003 SHALL have parameter BLINK_CYCLES, 12500000, pclk cycles per cursor blink phase.
REQ-004 SHALL have port pclk  in  1  pixel clock (25 MHz), sole clock.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port h_addr  in  10  current pixel column from the VGA timing controller.
REQ-007 SHALL have port v_addr  in  10  current pixel row from the VGA timing controller.
REQ-008 SHALL have port valid  in  1  active-video flag from the VGA timing controller.
REQ-009 SHALL have port vga_data  out  24  RGB pixel {R,G,B} to the VGA timing controller.
REQ-010 SHALL have port wr_valid  in  1  character write request.
REQ-011 SHALL have port wr_char  in  8  ASCII code, stable while wr_valid=1.
REQ-012 SHALL have port wr_ready  out  1  write accepted when wr_valid & wr_ready at pclk rise.
REQ-013 SHALL have port font_addr  out  12  {char[7:0], glyph_row[3:0]} to external font ROM.
REQ-014 SHALL have port font_data  in  8  glyph row, valid 1 cycle after font_addr; bit 7 = leftmost pixel.

Function
REQ-015 SHALL hold a 70x30 text buffer (2100 x 8 bit, dual-port), cell 9x16 px; glyph occupies px 0-7, px 8 always background.
REQ-016 SHALL map logical row r to physical row (top + r) mod 30; top is a 5-bit register, 0..29.
REQ-017 SHALL implement states INIT, IDLE, CLEAR; wr_ready=1 only in IDLE.
REQ-018 INIT SHALL write 0x20 to all 2100 cells, one per cycle (2100 cycles), then enter IDLE with cursor (col 0,row 0), top=0.
REQ-019 In IDLE, accepted code 0x20-0x7E SHALL be stored at cursor cell and col incremented; if col was 69, col=0 and newline performed.
REQ-020 Accepted 0x0A SHALL set col=0 and perform newline.
REQ-021 Accepted 0x08 with col>0 SHALL decrement col and store 0x20 at the new cursor cell; with col=0 SHALL have no effect (no reverse wrap).
REQ-022 Any other accepted code SHALL be consumed with no effect.
REQ-023 Newline with row<29 SHALL increment row, remain IDLE.
REQ-024 Newline with row=29 SHALL set top=(top+1) mod 30, keep row=29, enter CLEAR.
REQ-025 CLEAR SHALL write 0x20 to the 70 cells of the new logical row 29, one per cycle (70 cycles), then return to IDLE.
REQ-026 Render pipeline SHALL have fixed latency 3 pclk: vga_data (registered) at cycle t+3 reflects h_addr/v_addr/valid sampled at t.
REQ-027 Pipeline: t compute col=h_addr/9, px=h_addr%9, row=v_addr/16, gy=v_addr%16, issue text read; t+1 drive font_addr; t+2 font_data returns; t+3 vga_data registered.
REQ-028 vga_data SHALL be 0 when delayed valid=0, BG_COLOR when h_addr>=630 or px=8, else FG_COLOR if font_data[7-px]=1 else BG_COLOR.
REQ-029 A blink counter SHALL toggle blink flag every BLINK_CYCLES; with blink=1 the cursor cell SHALL render with FG/BG swapped (including px 8).
REQ-030 Render read colliding with same-cycle write to same cell SHALL return old data; the write SHALL never be delayed by rendering.
REQ-031 Pipeline SHALL run continuously in all states; text buffer contents during INIT/CLEAR render as-is.

Reset
REQ-032 reset SHALL enter INIT, set cursor (0,0), top=0, blink=0, blink counter=0, clear pipeline valid bits.
REQ-033 During and the cycle after reset, vga_data=0, wr_ready=0, font_addr=0.
REQ-034 Reset asserted mid-INIT or mid-CLEAR SHALL restart INIT from cell 0; any in-flight write is lost.

Verification
REQ-035 Reset 1 cycle, idle -> wr_ready=0 for exactly 2100 cycles, then 1; vga_data=0 throughout with valid=0.
REQ-036 After INIT write 0x41, font_data=8'h80 for char 0x41 -> pixel (0,0) vga_data=FG_COLOR 3 cycles after sample; (1,0) BG_COLOR; font_addr=12'h410 for v_addr=0.
REQ-037 Write 70 x 0x41 from (0,0) -> cursor (0,1); 71st char stored at physical row 1, col 0.
REQ-038 With cursor at row 29 write 0x0A -> top increments, wr_ready=0 for 70 cycles, row 29 reads all 0x20, prior row 29 content now at row 28.
REQ-039 Cursor col 0 write 0x08 -> cursor and buffer unchanged; at col 5 -> col 4, cell holds 0x20.
REQ-040 BLINK_CYCLES=4, cursor at (0,0), font_data=0 -> pixel (0,0) alternates BG/FG every 4 cycles; valid=0 -> vga_data=0.
